// File: rtl/demux1x8x1_collect_if.sv
// rtl/demux1x8x1_collect_if.sv - Bus bundle for the 1-to-8 serial lane collector.
//
// Signals:
//   In, Sel, In_valid  : serial bit, destination lane and its valid (producer -> block)
//   In_ready           : block can take In/Sel this cycle
//   Out_0 .. Out_7     : registered lane values
//   Lane_mask          : lanes written since the last handoff
//   Out_valid          : all eight lanes written, word offered
//   Out_ready          : consumer takes the word
//   Overwrite          : one-cycle pulse after a write to an already-written lane
// Modports: master drives the producer/consumer side, slave is the collector.
interface demux1x8x1_collect_if;
    logic       In;
    logic [2:0] Sel;
    logic       In_valid;
    logic       In_ready;
    logic       Out_0;
    logic       Out_1;
    logic       Out_2;
    logic       Out_3;
    logic       Out_4;
    logic       Out_5;
    logic       Out_6;
    logic       Out_7;
    logic [7:0] Lane_mask;
    logic       Out_valid;
    logic       Out_ready;
    logic       Overwrite;

    modport master (
        output In, Sel, In_valid, Out_ready,
        input  In_ready, Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7,
        input  Lane_mask, Out_valid, Overwrite
    );

    modport slave (
        input  In, Sel, In_valid, Out_ready,
        output In_ready, Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7,
        output Lane_mask, Out_valid, Overwrite
    );
endinterface

// File: rtl/demux1x8x1_collect.sv
// rtl/demux1x8x1_collect.sv - Routes serial bits into eight lanes and offers the full word.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : demux1x8x1_collect_if.slave (write side In/Sel/In_valid/In_ready,
//           word side Out_0..Out_7/Lane_mask/Out_valid/Out_ready, Overwrite pulse)
// Parameter:
//   CLEAR_ON_READ : 1 clears the lanes when the word is handed off, 0 keeps them
module demux1x8x1_collect #(
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    demux1x8x1_collect_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] lanes;
    logic [7:0] lanes_next;
    logic [7:0] mask;
    logic [7:0] mask_next;
    logic       out_valid;
    logic       overwrite;
    logic       overwrite_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lanes     <= 8'h00;
            mask      <= 8'h00;
            out_valid <= 1'b0;
            overwrite <= 1'b0;
        end else begin
            state     <= state_next;
            lanes     <= lanes_next;
            mask      <= mask_next;
            // Out_valid is a flop that mirrors "next state is FULL", so it
            // rises the cycle after the completing write and drops with handoff.
            out_valid <= (state_next == FULL);
            overwrite <= overwrite_next;
        end
    end

    always_comb begin
        state_next     = state;
        lanes_next     = lanes;
        mask_next      = mask;
        overwrite_next = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (bus.In_valid) begin
                    lanes_next[bus.Sel] = bus.In;
                    mask_next[bus.Sel]  = 1'b1;
                    overwrite_next      = mask[bus.Sel];
                    state_next          = (mask_next == 8'hFF) ? FULL : COLLECT;
                end
            end
            FULL: begin
                // Writes are ignored here; only the consumer moves us on.
                if (bus.Out_ready) begin
                    state_next = IDLE;
                    mask_next  = 8'h00;
                    if (CLEAR_ON_READ) begin
                        lanes_next = 8'h00;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ready is held low while reset is asserted so no producer sees a phantom accept.
    assign bus.In_ready  = rst_n && (state != FULL);
    assign bus.Out_0     = lanes[0];
    assign bus.Out_1     = lanes[1];
    assign bus.Out_2     = lanes[2];
    assign bus.Out_3     = lanes[3];
    assign bus.Out_4     = lanes[4];
    assign bus.Out_5     = lanes[5];
    assign bus.Out_6     = lanes[6];
    assign bus.Out_7     = lanes[7];
    assign bus.Lane_mask = mask;
    assign bus.Out_valid = out_valid;
    assign bus.Overwrite = overwrite;

endmodule

// File: tb/tb_demux1x8x1_collect.sv
// tb/tb_demux1x8x1_collect.sv - Directed self-checking bench for demux1x8x1_collect.
module tb_demux1x8x1_collect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_bit;
    logic [2:0] sel;
    logic       in_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux1x8x1_collect_if bc ();
    demux1x8x1_collect_if bh ();

    assign bc.In        = in_bit;
    assign bc.Sel       = sel;
    assign bc.In_valid  = in_valid;
    assign bc.Out_ready = out_ready;
    assign bh.In        = in_bit;
    assign bh.Sel       = sel;
    assign bh.In_valid  = in_valid;
    assign bh.Out_ready = out_ready;

    demux1x8x1_collect #(.CLEAR_ON_READ(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc.slave));
    demux1x8x1_collect #(.CLEAR_ON_READ(1'b0)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bh.slave));

    wire [7:0] word_c = {bc.Out_7, bc.Out_6, bc.Out_5, bc.Out_4, bc.Out_3, bc.Out_2, bc.Out_1, bc.Out_0};
    wire [7:0] word_h = {bh.Out_7, bh.Out_6, bh.Out_5, bh.Out_4, bh.Out_3, bh.Out_2, bh.Out_1, bh.Out_0};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic b);
        in_valid = 1'b1;
        sel      = s;
        in_bit   = b;
        step();
        in_valid = 1'b0;
    endtask

    // Full status check on both instances; word_h is the CLEAR_ON_READ=0 copy.
    task automatic chk_all(input string tag, input logic [7:0] msk, input logic [7:0] wc,
                           input logic [7:0] wh, input logic ovl, input logic rdy, input logic ovw);
        chk({tag, ".mask_c"}, bc.Lane_mask, msk);
        chk({tag, ".mask_h"}, bh.Lane_mask, msk);
        chk({tag, ".word_c"}, word_c, wc);
        chk({tag, ".word_h"}, word_h, wh);
        chk({tag, ".valid_c"}, {7'd0, bc.Out_valid}, {7'd0, ovl});
        chk({tag, ".valid_h"}, {7'd0, bh.Out_valid}, {7'd0, ovl});
        chk({tag, ".ready_c"}, {7'd0, bc.In_ready}, {7'd0, rdy});
        chk({tag, ".ready_h"}, {7'd0, bh.In_ready}, {7'd0, rdy});
        chk({tag, ".ovw_c"}, {7'd0, bc.Overwrite}, {7'd0, ovw});
        chk({tag, ".ovw_h"}, {7'd0, bh.Overwrite}, {7'd0, ovw});
    endtask

    initial begin
        logic [7:0] pat;
        pat       = 8'b01001101;
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        sel       = 3'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state, with a write pending to show reset wins
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk_all("rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("rst_rel", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Eight consecutive writes building 8'b01001101; Out_ready ignored while collecting
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            sel      = 3'(i);
            in_bit   = pat[i];
            step();
        end
        chk_all("w7", 8'h7F, 8'h4D, 8'h4D, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        wr(3'd7, pat[7]);
        chk_all("w8", 8'hFF, 8'h4D, 8'h4D, 1'b1, 1'b0, 1'b0);

        // FULL holds for 5 cycles with writes attempted
        in_valid = 1'b1;
        sel      = 3'd0;
        in_bit   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("hold", 8'hFF, 8'h4D, 8'h4D, 1'b1, 1'b0, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_all("handoff", 8'h00, 8'h00, 8'h4D, 1'b0, 1'b1, 1'b0);

        // First write after handoff: held lanes keep the prior word except lane 2
        wr(3'd2, 1'b0);
        chk_all("post_ho", 8'h04, 8'h00, 8'h49, 1'b0, 1'b1, 1'b0);

        // Reset mid-collect discards everything
        rst_n = 1'b0;
        step();
        chk_all("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Overwrite of lane 3
        wr(3'd3, 1'b1);
        chk_all("ow1", 8'h08, 8'h08, 8'h08, 1'b0, 1'b1, 1'b0);
        wr(3'd3, 1'b0);
        chk_all("ow2", 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        chk_all("ow3", 8'h08, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Write lanes 0..5, then one-cycle reset; eight fresh writes still needed
        for (int i = 0; i < 6; i++) wr(3'(i), 1'b1);
        chk_all("w6", 8'h3F, 8'h3F, 8'h3F, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        chk_all("rst_w6", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Out_ready held high: two back-to-back words, each Out_valid lasting one cycle
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            sel      = 3'(7 - i);
            in_bit   = 1'b1;
            step();
        end
        chk_all("a7", 8'hFE, 8'hFE, 8'hFE, 1'b0, 1'b1, 1'b0);
        wr(3'd0, 1'b0);
        chk_all("a8", 8'hFF, 8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("a_ho", 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel      = 3'(i);
            in_bit   = (i == 5);
            step();
        end
        in_valid = 1'b0;
        chk_all("b8", 8'hFF, 8'h20, 8'h20, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("b_ho", 8'h00, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("b_idle", 8'h00, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1x8x1_collect.md
DEMUX1X8X1_COLLECT -- requirements
Module: demux1x8x1_collect

Interface
REQ-001 Parameter CLEAR_ON_READ, default 1: 1 = lane registers cleared to 0 on word handoff; 0 = lanes keep their values.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 In  input  1  serial data bit to be routed.
REQ-005 Sel  input  3  destination lane index 0..7.
REQ-006 In_valid  input  1  In/Sel valid this cycle.
REQ-007 In_ready  output  1  block can accept In/Sel this cycle.
REQ-008 Out_0 .. Out_7  output  1 each  registered lane values; Out_k is lane k.
REQ-009 Lane_mask  output  8  bit k = 1 when lane k has been written since the last handoff.
REQ-010 Out_valid  output  1  all 8 lanes written; word Out_0..Out_7 is stable and offered.
REQ-011 Out_ready  input  1  consumer takes the word this cycle.
REQ-012 Overwrite  output  1  one-cycle pulse: the previous accepted write targeted an already-written lane.

Function
REQ-013 Three states SHALL be used: IDLE (Lane_mask = 0), COLLECT (mask partial), FULL (mask = 8'hFF).
REQ-014 In_ready SHALL be 1 in IDLE and COLLECT and 0 in FULL, decoded combinationally from state.
REQ-015 A write SHALL be accepted on a rising edge when In_valid = 1 and In_ready = 1.
REQ-016 An accepted write SHALL set lane Sel to In and set Lane_mask[Sel]; both are visible one cycle later.
REQ-017 Lanes other than Sel SHALL be unchanged by a write.
REQ-018 IDLE -> COLLECT SHALL occur on any accepted write that leaves the mask not all ones.
REQ-019 IDLE/COLLECT -> FULL SHALL occur on the accepted write that makes the mask 8'hFF.
REQ-020 Out_valid SHALL be registered: 1 exactly while in FULL, first asserted the cycle after the completing write.
REQ-021 In FULL, In_valid SHALL be ignored, and lanes and mask SHALL hold.
REQ-022 In FULL, Out_valid = 1 and Out_ready = 1 on an edge SHALL complete the handoff: next cycle state IDLE, mask 0, Out_valid 0.
REQ-023 On handoff with CLEAR_ON_READ = 1, all lanes SHALL become 0; with CLEAR_ON_READ = 0, all lanes SHALL hold.
REQ-024 Out_ready outside FULL SHALL be ignored.
REQ-025 An accepted write to a lane whose mask bit is already 1 SHALL overwrite the lane value, leave the mask unchanged, and pulse Overwrite high for exactly the next cycle.
REQ-026 Back-to-back accepted writes SHALL sustain one write per cycle; throughput is 8 cycles per word minimum plus 1 handoff cycle.
REQ-027 The first write accepted after handoff (In_ready returns to 1 in the IDLE cycle) SHALL be a normal write into the cleared or held lanes.
REQ-028 Out_0..Out_7 SHALL always show the current lane registers, including partial contents during COLLECT.

Reset
REQ-029 With rst_n low at a rising edge, the block SHALL enter IDLE and drive Lane_mask = 0, Out_0..Out_7 = 0, Out_valid = 0, and Overwrite = 0.
REQ-030 In_ready SHALL be 0 in any cycle where rst_n is low.
REQ-031 Reset asserted mid-COLLECT or in FULL SHALL discard partial or offered data; no handoff occurs.
REQ-032 Reset SHALL take priority over a simultaneous write or handoff.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then write Sel = 0..7 with In = 1,0,1,1,0,0,1,0 on consecutive cycles -> Out_valid = 1 the cycle after the 8th write; {Out_7..Out_0} = 8'b01001101; In_ready = 0.
- Hold Out_ready = 0 for 5 cycles in FULL while driving In_valid = 1 -> word and Out_valid stable; no lane changes. Then Out_ready = 1 -> next cycle Out_valid = 0, mask = 0, lanes = 0 (CLEAR_ON_READ = 1).
- Write Sel = 3 with In = 1, then Sel = 3 with In = 0 -> Lane_mask = 8'h08, Out_3 = 0, Overwrite pulses one cycle.
- Write lanes 0..5, then drop rst_n for one cycle -> all outputs 0, state IDLE; 8 fresh writes are still required for Out_valid.
- CLEAR_ON_READ = 0: complete one word, hand it off, write only Sel = 2 with In = 0 -> Out_2 = 0; other lanes retain the prior word; Lane_mask = 8'h04.
- Drive Out_ready = 1 continuously from reset and write 8 lanes twice -> two handoffs; each Out_valid is high for exactly 1 cycle.
